floo_route_fork: RTL

Multicast-capable XY route selector with output fork handshake for a FlooNoC router input port. It computes the set of output directions for an incoming flit, unicast or mask-encoded multicast. It drives the flit to every selected output, tracks per output which copies have been accepted, and releases the input only after all copies are delivered. The route is locked for the duration of a multi-flit packet. The block sits between an input buffer and the switch-allocation/crossbar stage.

---
 rtl/floo_route_fork.sv | 131 +++++++++++++
 1 files changed

// File: rtl/floo_route_fork.sv
// floo_route_fork: XY / mask-multicast route decode for one router input port,
// with packet route locking and a fork handshake that releases the input only
// after every selected output has accepted its copy.

package floo_route_fork_pkg;
    typedef struct packed {
        logic [2:0] y;
        logic [2:0] x;
    } id_t;

    typedef struct packed {
        id_t  dst_id;
        id_t  dst_mask_id;
        logic mcast_flag;
        logic last;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;
endpackage

module floo_route_fork #(
    parameter int unsigned XWidth      = 3,
    parameter int unsigned YWidth      = 3,
    parameter bit          McastEn     = 1'b1,
    parameter bit          LockRouting = 1'b1,
    parameter type         id_t        = floo_route_fork_pkg::id_t,
    parameter type         flit_t      = floo_route_fork_pkg::flit_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  id_t         xy_id_i,
    input  flit_t       flit_i,
    input  logic        valid_i,
    output logic        ready_o,
    output flit_t       flit_o,
    output logic [4:0]  valid_o,
    input  logic [4:0]  ready_i,
    output logic [4:0]  route_sel_o,
    output logic        lock_err_o
);
    // Route bit positions: 0 Eject, 1 South, 2 West, 3 North, 4 East.

    logic [XWidth-1:0] dx, mx, ox, lo_x, hi_x;
    logic [YWidth-1:0] dy, my, oy, lo_y, hi_y;
    logic              xhit, yhit;
    logic [4:0]        sel;

    logic [4:0] served_q, served_d;
    logic [4:0] route_q, route_d;
    logic       locked_q, locked_d;
    logic       lock_err_q, lock_err_d;
    logic [4:0] fire;
    logic       hs;

    assign dx = flit_i.hdr.dst_id.x;
    assign dy = flit_i.hdr.dst_id.y;
    assign mx = flit_i.hdr.dst_mask_id.x;
    assign my = flit_i.hdr.dst_mask_id.y;
    assign ox = xy_id_i.x;
    assign oy = xy_id_i.y;

    // Route decode: dimension-ordered unicast, or the bounding box of the
    // masked destination set for multicast (mask bit 1 = don't care).
    always_comb begin
        lo_x = dx & ~mx;
        hi_x = dx | mx;
        lo_y = dy & ~my;
        hi_y = dy | my;
        xhit = ((ox & ~mx) == lo_x);
        yhit = ((oy & ~my) == lo_y);
        sel  = '0;
        if (McastEn && flit_i.hdr.mcast_flag) begin
            sel[0] = xhit & yhit;
            sel[1] = xhit & (lo_y < oy);
            sel[2] = (lo_x < ox);
            sel[3] = xhit & (hi_y > oy);
            sel[4] = (hi_x > ox);
        end else if (dx == ox && dy == oy) begin
            sel[0] = 1'b1;
        end else if (dx == ox) begin
            if (dy < oy) sel[1] = 1'b1;
            else         sel[3] = 1'b1;
        end else begin
            if (dx < ox) sel[2] = 1'b1;
            else         sel[4] = 1'b1;
        end
    end

    // Output side: reset forces every handshake output quiet even though the
    // decode itself is purely combinational.
    assign flit_o      = flit_i;
    assign route_sel_o = rst_i ? 5'b0 : (locked_q ? route_q : sel);
    assign valid_o     = (rst_i || !valid_i) ? 5'b0 : (route_sel_o & ~served_q);
    assign ready_o     = ~rst_i & valid_i & (&(~route_sel_o | served_q | ready_i));
    assign fire        = valid_o & ready_i;
    assign hs          = valid_i & ready_o;
    assign lock_err_o  = lock_err_q;

    // Next state: served copies accumulate until the input handshake; the
    // route is captured on the first flit of a packet and held until last.
    always_comb begin
        served_d   = hs ? 5'b0 : (served_q | fire);
        locked_d   = locked_q;
        route_d    = route_q;
        lock_err_d = lock_err_q;
        if (LockRouting && hs) begin
            locked_d = ~flit_i.hdr.last;
            if (!locked_q) route_d = sel;
            if (locked_q && (sel != route_q)) lock_err_d = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            served_q   <= '0;
            route_q    <= '0;
            locked_q   <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            served_q   <= served_d;
            route_q    <= route_d;
            locked_q   <= locked_d;
            lock_err_q <= lock_err_d;
        end
    end

endmodule
